// File: rtl/dsp_duc_tx_pkg.sv
// Shared constants, sample types and the output saturation helper for the DUC transmit path.
package dsp_duc_tx_pkg;

    localparam int LUT_DEPTH  = 256;
    localparam int LUT_AW     = $clog2(LUT_DEPTH);
    localparam int SAMPLE_W   = 16;
    localparam int ACC_W      = 33;
    localparam int FRAC_SHIFT = 15;

    localparam logic signed [ACC_W-1:0] ROUND_CONST    = 33'sd16384;
    localparam logic [LUT_AW-1:0]       QUARTER_OFFSET = LUT_AW'(LUT_DEPTH / 4);

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] i;
        logic signed [SAMPLE_W-1:0] q;
    } iq_t;

    function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [ACC_W-1:0] v);
        logic signed [SAMPLE_W-1:0] r;
        if (v > 33'sd32767) begin
            r = 16'sh7FFF;
        end else if (v < -33'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/nco_sin_lut.sv
// Dual-read sine ROM (256 x 16 bit, amplitude 32767) with one registered output per port.
// Only the first quarter wave is stored; the rest is folded by symmetry.
module nco_sin_lut
    import dsp_duc_tx_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [LUT_AW-1:0]          sin_idx_i,
    input  logic [LUT_AW-1:0]          cos_idx_i,
    output logic signed [SAMPLE_W-1:0] sin_o,
    output logic signed [SAMPLE_W-1:0] cos_o
);

    function automatic logic signed [SAMPLE_W-1:0] quarter(input logic [6:0] k);
        logic signed [SAMPLE_W-1:0] v;
        case (k)
            7'd0:  v = 16'sd0;     7'd1:  v = 16'sd804;   7'd2:  v = 16'sd1608;  7'd3:  v = 16'sd2410;
            7'd4:  v = 16'sd3212;  7'd5:  v = 16'sd4011;  7'd6:  v = 16'sd4808;  7'd7:  v = 16'sd5602;
            7'd8:  v = 16'sd6393;  7'd9:  v = 16'sd7179;  7'd10: v = 16'sd7962;  7'd11: v = 16'sd8739;
            7'd12: v = 16'sd9512;  7'd13: v = 16'sd10278; 7'd14: v = 16'sd11039; 7'd15: v = 16'sd11793;
            7'd16: v = 16'sd12539; 7'd17: v = 16'sd13279; 7'd18: v = 16'sd14010; 7'd19: v = 16'sd14732;
            7'd20: v = 16'sd15446; 7'd21: v = 16'sd16151; 7'd22: v = 16'sd16846; 7'd23: v = 16'sd17530;
            7'd24: v = 16'sd18204; 7'd25: v = 16'sd18868; 7'd26: v = 16'sd19519; 7'd27: v = 16'sd20159;
            7'd28: v = 16'sd20787; 7'd29: v = 16'sd21403; 7'd30: v = 16'sd22005; 7'd31: v = 16'sd22594;
            7'd32: v = 16'sd23170; 7'd33: v = 16'sd23731; 7'd34: v = 16'sd24279; 7'd35: v = 16'sd24811;
            7'd36: v = 16'sd25329; 7'd37: v = 16'sd25832; 7'd38: v = 16'sd26319; 7'd39: v = 16'sd26790;
            7'd40: v = 16'sd27245; 7'd41: v = 16'sd27683; 7'd42: v = 16'sd28105; 7'd43: v = 16'sd28510;
            7'd44: v = 16'sd28898; 7'd45: v = 16'sd29268; 7'd46: v = 16'sd29621; 7'd47: v = 16'sd29956;
            7'd48: v = 16'sd30273; 7'd49: v = 16'sd30571; 7'd50: v = 16'sd30852; 7'd51: v = 16'sd31113;
            7'd52: v = 16'sd31356; 7'd53: v = 16'sd31580; 7'd54: v = 16'sd31785; 7'd55: v = 16'sd31971;
            7'd56: v = 16'sd32137; 7'd57: v = 16'sd32285; 7'd58: v = 16'sd32412; 7'd59: v = 16'sd32521;
            7'd60: v = 16'sd32609; 7'd61: v = 16'sd32678; 7'd62: v = 16'sd32728; 7'd63: v = 16'sd32757;
            7'd64: v = 16'sd32767;
            default: v = 16'sd0;
        endcase
        return v;
    endfunction

    // Second and fourth quarters mirror the index; the lower half of the circle negates.
    function automatic logic signed [SAMPLE_W-1:0] sine(input logic [LUT_AW-1:0] idx);
        logic [6:0]                 k;
        logic signed [SAMPLE_W-1:0] m;
        if (idx[6]) begin
            k = 7'd64 - {1'b0, idx[5:0]};
        end else begin
            k = {1'b0, idx[5:0]};
        end
        m = quarter(k);
        return idx[7] ? -m : m;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sin_o <= '0;
            cos_o <= '0;
        end else begin
            sin_o <= sine(sin_idx_i);
            cos_o <= sine(cos_idx_i);
        end
    end

endmodule

// File: rtl/dsp_duc_tx.sv
// Digital up-converter: IQ sample FIFO, zero-order hold at 1/INTERP rate, NCO quadrature mix
// to a real 16-bit DAC stream with round-half-up and saturation.
module dsp_duc_tx
    import dsp_duc_tx_pkg::*;
#(
    parameter logic [31:0] FREQ       = 32'h6400_0000,
    parameter int          INTERP     = 8,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [31:0]                data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic signed [SAMPLE_W-1:0] dac_data_o,
    output logic                       dac_valid_o,
    output logic                       underrun_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(INTERP);
    localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(INTERP - 1);

    logic [31:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push, pop, boundary;

    logic [CW-1:0] cnt_q, cnt_d;
    iq_t           hold_q, hold_d;
    logic          underrun_q, underrun_d;
    logic [31:0]   phase_q;

    logic signed [SAMPLE_W-1:0]   sin_s, cos_s;
    logic signed [2*SAMPLE_W-1:0] prod_ic_q, prod_qs_q;
    logic signed [ACC_W-1:0]      ext_ic, ext_qs, sum_q;
    logic signed [SAMPLE_W-1:0]   dac_q;
    logic [3:0]                   vld_q;

    assign ready_o  = (count_q != DEPTH_C);
    assign push     = valid_i & ready_o;
    assign boundary = en_i & (cnt_q == CNT_LAST);
    assign pop      = boundary & (count_q != '0);

    // Sample FIFO; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        underrun_d = underrun_q;
        if (!en_i) begin
            cnt_d  = '0;
            hold_d = '0;
        end else if (boundary) begin
            cnt_d = '0;
            if (count_q != '0) begin
                hold_d = fifo_mem_q[rd_ptr_q];
            end else begin
                hold_d     = '0;
                underrun_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The LUT registers its output on the same edge the hold register loads, so both use one phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            hold_q     <= '0;
            underrun_q <= 1'b0;
            phase_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            underrun_q <= underrun_d;
            phase_q    <= phase_q + FREQ;
        end
    end

    nco_sin_lut u_lut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sin_idx_i (phase_q[31:24]),
        .cos_idx_i (phase_q[31:24] + QUARTER_OFFSET),
        .sin_o     (sin_s),
        .cos_o     (cos_s)
    );

    assign ext_ic = {prod_ic_q[2*SAMPLE_W-1], prod_ic_q};
    assign ext_qs = {prod_qs_q[2*SAMPLE_W-1], prod_qs_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prod_ic_q <= '0;
            prod_qs_q <= '0;
            sum_q     <= '0;
            dac_q     <= '0;
            vld_q     <= '0;
        end else begin
            prod_ic_q <= $signed(hold_q.i) * cos_s;
            prod_qs_q <= $signed(hold_q.q) * sin_s;
            sum_q     <= (ext_ic - ext_qs + ROUND_CONST) >>> FRAC_SHIFT;
            dac_q     <= sat_sample(sum_q);
            vld_q     <= {vld_q[2:0], 1'b1};
        end
    end

    assign dac_data_o  = dac_q;
    assign dac_valid_o = vld_q[3];
    assign underrun_o  = underrun_q;

endmodule

// File: doc/dsp_duc_tx.md
DSP_DUC_TX -- requirements
Module: dsp_duc_tx

Interface
REQ-001 FREQ, 32'h64000000, NCO phase increment per clk (75 MHz carrier).
REQ-002 INTERP, 8, interpolation factor (clk cycles per IQ sample), range 2..64.
REQ-003 FIFO_DEPTH, 4, input sample FIFO depth, power of two, 2..16.
REQ-004 clk  input  1  single system clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  transmit enable.
REQ-007 data  input  32  {I[31:16], Q[15:0]}, signed two's complement each.
REQ-008 valid  input  1  data qualifier.
REQ-009 ready  output  1  FIFO can accept a sample this cycle.
REQ-010 dac_data  output  16  signed real upconverted sample.
REQ-011 dac_valid  output  1  dac_data qualifier.
REQ-012 underrun  output  1  sticky flag; FIFO empty at a sample boundary while en=1.

Function
REQ-013 ready SHALL equal !full, combinational from FIFO state; push occurs when valid&&ready.
REQ-014 Push and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-015 Sample counter SHALL count 0..INTERP-1 and wrap while en=1; held at 0 while en=0.
REQ-016 At counter==INTERP-1 with FIFO non-empty: pop, hold register <= popped {I,Q}.
REQ-017 At counter==INTERP-1 with FIFO empty: hold register <= 0, underrun <= 1; underrun clears only on rst.
REQ-018 While en=0: hold register <= 0, no pops, no underrun set; FIFO keeps accepting pushes.
REQ-019 Phase accumulator (32 bit) SHALL add FREQ every clk, wrap mod 2^32, independent of en.
REQ-020 NCO index = phase[31:24]; sin = LUT[idx], cos = LUT[idx+64 mod 256]; LUT 256 entries, 16-bit signed, round(32767*sin(2*pi*k/256)); LUT read latency 1 cycle.
REQ-021 Mix: acc = I*cos - Q*sin, 16x16 signed products, 33-bit signed sum.
REQ-022 Rounding: (acc + 2^14) >>> 15 arithmetic; saturate to [-32768, 32767].
REQ-023 Pipeline: hold/LUT stage, multiply stage, sum+round stage, saturate/output stage; dac_data SHALL reflect a hold register value and its phase 3 clk after the hold register update.
REQ-024 Phase used in a product SHALL be the phase of the same cycle the hold value is sampled (LUT and hold aligned).
REQ-025 dac_valid SHALL go 1 on the 4th clk after rst deassertion and stay 1 continuously (DAC stream never gaps); dac_data = 0 while the pipeline carries reset values.

Reset
REQ-026 rst=1 SHALL set: phase 0, counter 0, FIFO empty, hold 0, all pipeline regs 0, dac_data 0, dac_valid 0, underrun 0, ready 1 on the cycle after.
REQ-027 rst mid-operation SHALL discard FIFO contents and in-flight pipeline data within one clk; push attempted during rst is ignored.

Structure
REQ-028 Shared package SHALL hold LUT depth (256), sample width (16), accumulator width (33), rounding constant, quarter-period offset (64).
REQ-029 Sine ROM SHALL be one sub-module, nco_sin_lut, dual read port (sin, cos index), 1-cycle registered output.
REQ-030 FIFO SHALL be in-module (pointer + count), no vendor IP.

Verification
REQ-031 FREQ=0, en=1, push I=16'h4000, Q=0 -> after first pop, dac_data=16384 steady, underrun=0 while refilled every 8 clk.
REQ-032 FREQ=32'h20000000, hold I=32767, Q=-32768 -> at idx 32 (cos=sin=23170) dac_data saturates to 32767; at idx 160 saturates to -32768.
REQ-033 After rst, en=1, no pushes -> at clk 7 underrun=1, dac_data=0 from clk 11 onward; stays 1 after later pushes.
REQ-034 After rst, en=0, valid=1 every clk -> 4 samples accepted (clk 0..3), ready=0 from clk 4; set en=1 -> ready returns 1 the clk after the pop at counter==7.
REQ-035 Mid-stream rst pulse with FIFO holding 3 samples -> next cycle FIFO empty, ready=1, dac_valid=0, dac_data=0; dac_valid=1 again 4 clk after release.
REQ-036 INTERP=2, FREQ=0, alternating I=+1000/-1000 pushed continuously -> dac_data toggles 1000/-1000 (rounded) each 2 clk, no underrun.
